// File: rtl/mem_port_arbiter.sv
// Single byte-wide RAM port shared between instruction fetch and load/store.
// Each 1/2/4-byte access is sequenced as a multi-cycle byte transfer; MEM has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_cancel,
  output logic [31:0]           if_rdata,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            cnt;
  logic [1:0]            last;      // index of the final byte (nbytes-1)
  logic [1:0]            len_last;
  logic                  gnt_if, gnt_mem, we;
  logic [ADDR_WIDTH-1:0] base;
  logic [3:0][7:0]       wbuf, rbuf;
  logic                  cancel;

  always_comb begin
    case (mem_len)
      2'd0:    len_last = 2'd0;
      2'd1:    len_last = 2'd1;
      default: len_last = 2'd3;
    endcase
  end

  // A cancel only applies to an IF access that already left IDLE
  assign cancel = if_cancel && gnt_if && (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_req || if_req) state_nxt = XFER;
      XFER: if (cnt == last)       state_nxt = we ? DONE : TAIL;
      TAIL:                        state_nxt = DONE;
      DONE:                        state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
    if (cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      last    <= '0;
      gnt_if  <= 1'b0;
      gnt_mem <= 1'b0;
      we      <= 1'b0;
      base    <= '0;
      wbuf    <= '0;
      rbuf    <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          cnt  <= '0;
          rbuf <= '0;
          if (mem_req) begin
            gnt_mem <= 1'b1;
            base    <= mem_addr;
            we      <= mem_we;
            last    <= len_last;
            wbuf    <= mem_wdata;
          end else if (if_req) begin
            gnt_if <= 1'b1;
            base   <= if_addr;
            we     <= 1'b0;
            last   <= 2'd3;
            wbuf   <= '0;
          end
        end
        XFER: begin
          cnt <= cnt + 2'd1;
          // ram_din lags the address by one cycle, so byte cnt-1 is on the bus now
          if (!we && cnt != 2'd0) rbuf[cnt - 2'd1] <= ram_din;
        end
        TAIL: rbuf[last] <= ram_din;
        DONE: begin
          gnt_if  <= 1'b0;
          gnt_mem <= 1'b0;
        end
        default: ;
      endcase
      if (cancel) gnt_if <= 1'b0;
    end
  end

  assign busy     = (state != IDLE);
  assign ram_addr = (state == XFER) ? base + ADDR_WIDTH'(cnt) : '0;
  assign ram_wr   = (state == XFER) && we && rdy;
  assign ram_dout = ((state == XFER) && we) ? wbuf[cnt] : 8'h00;

  // Done is qualified by rdy so a pause never stretches the pulse
  assign if_done   = (state == DONE) && gnt_if && rdy && !if_cancel;
  assign mem_done  = (state == DONE) && gnt_mem && rdy;
  assign if_rdata  = if_done  ? rbuf : 32'h0;
  assign mem_rdata = mem_done ? rbuf : 32'h0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and load/store (MEM stage).
- Sequences each 1/2/4-byte access as a multi-cycle byte transfer, assembling little-endian read data and splitting write data.
- Returns a one-cycle done pulse to the granted requester; until then the pipeline registers hold via the stall controller.

Parameters:
- ADDR_WIDTH, 32, width of request addresses and ram_addr.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global run enable; low = pause.
- if_req  input  1  IF read request; level, held until if_done.
- if_addr  input  ADDR_WIDTH  IF byte address.
- if_cancel  input  1  abort the in-flight IF access (branch redirect).
- if_rdata  output  32  fetched word, valid with if_done.
- if_done  output  1  one-cycle IF completion pulse.
- mem_req  input  1  MEM request; level, held until mem_done.
- mem_we  input  1  1 = store, 0 = load.
- mem_len  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_addr  input  ADDR_WIDTH  MEM byte address.
- mem_wdata  input  32  store data, low bytes used.
- mem_rdata  output  32  load data, zero-extended; valid with mem_done.
- mem_done  output  1  one-cycle MEM completion pulse.
- busy  output  1  high in every state except IDLE.
- ram_addr  output  ADDR_WIDTH  RAM byte address.
- ram_wr  output  1  RAM write strobe.
- ram_dout  output  8  byte to RAM.
- ram_din  input  8  byte from RAM; equals mem[address presented in the previous active cycle].

Behaviour:
- Reset (rst low, async): state IDLE, cnt 0, grant none, buffer 0; all outputs 0.
- rdy low:
  - All registers freeze and ram_wr is forced 0.
  - ram_din is guaranteed stable during a pause because the RAM is enabled by the same rdy.
  - Resuming continues exactly where the access stopped.
- States:
  - IDLE:
    - If mem_req, grant MEM; otherwise if if_req, grant IF. MEM has fixed priority because it is the older instruction.
    - Latch addr, we (IF reads only), nbytes (1/2/4) and wdata; cnt <= 0; go XFER.
    - Nothing is issued to the RAM in the grant cycle.
  - XFER:
    - ram_addr = base + cnt; ram_wr = we; ram_dout = wdata[8*cnt+7 : 8*cnt].
    - For reads with cnt ≥ 1, capture ram_din into buf byte cnt-1.
    - cnt increments each cycle.
    - At cnt == nbytes-1: a write goes to DONE, a read goes to TAIL.
  - TAIL: capture ram_din into buf byte nbytes-1; ram_wr 0; go DONE.
  - DONE:
    - The granted requester's done = 1 and its rdata = buf zero-extended to 32 bits.
    - Unused upper bytes are 0 and buf is cleared at grant.
    - Go IDLE.
- Outside XFER: ram_addr = 0 and ram_wr = 0.
- Latency from the request cycle to the done cycle:
  - word read 6, half read 4, byte read 3;
  - word write 5, half write 3, byte write 2.
- Requesters deassert req in the cycle after done. A req still high in IDLE is treated as a new request.
- Address arithmetic base + cnt wraps modulo 2^ADDR_WIDTH.
- if_cancel:
  - If the grant is IF and the state is XFER, TAIL or DONE, go IDLE next edge with no if_done. If already in DONE, if_done is masked to 0 that cycle.
  - if_cancel is ignored when the grant is MEM or the state is IDLE.
- Simultaneous if_req and mem_req in IDLE: MEM wins; IF waits and is granted at the first IDLE cycle with mem_req low.
- A request arriving mid-transfer is not sampled until IDLE. A held grant is never preempted.
- Reset mid-transfer aborts it immediately. A partial write may leave earlier bytes written; this is accepted.

Test Plan:
- IF fetch, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> ram_addr 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_rdata=0x00000513.
- MEM word store, addr 0x2000, wdata 0xDEADBEEF -> ram_wr=1 for 4 cycles writing EF,BE,AD,DE to 0x2000..0x2003; mem_done in cycle 5; RAM readback matches.
- MEM half load, addr 0x11, RAM[0x11..0x12]=FF,80 -> mem_done in cycle 4, mem_rdata=0x000080FF.
- if_req and mem_req (byte load) both asserted in the same cycle -> MEM done first; IF granted in the IDLE cycle after mem_done; no RAM access overlap.
- IF word fetch, if_cancel pulsed in XFER cnt=2 -> IDLE next cycle, no if_done, ram_wr stays 0, busy drops.
- Word read with rdy low for 3 cycles during XFER cnt=1 -> ram_addr and state held; if_rdata still correct; if_done delayed by exactly 3 cycles. Also: rst pulsed during a store -> all outputs 0 immediately; state IDLE.
